uart_rx_core: RTL and testbench

//  UART receiver; the receive-side counterpart of our UART transmit path, in the same multi-clock system.
//  - Oversamples RX_IN at Prescale clocks per bit and recovers frames: start, 8 data bits LSB first,

---
 rtl/uart_rx_core.sv | 163 ++++++++++++++++
 tb/tb_uart_rx_core.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_core.sv
// UART receiver: 2-flop input sync, 3-point majority oversampling,
// start/data/parity/stop framing with one-cycle status strobes.
module uart_rx_core #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESC_W    = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  RX_IN,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic [PRESC_W-1:0]    Prescale,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  Data_Valid,
  output logic                  par_err,
  output logic                  stp_err
);

  localparam int BW = $clog2(DATA_WIDTH);
  localparam logic [PRESC_W-1:0] ONE = PRESC_W'(1);
  localparam logic [PRESC_W-1:0] TWO = PRESC_W'(2);
  localparam logic [BW-1:0] BONE = BW'(1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP
  } state_e;

  state_e                  state_q;
  logic                    rx_meta_q;
  logic                    rx_s_q;
  logic [PRESC_W-1:0]      edge_q;
  logic [BW-1:0]           bit_q;
  logic [PRESC_W-1:0]      presc_q;
  logic                    par_en_q;
  logic                    par_typ_q;
  logic [2:0]              smp_q;
  logic [DATA_WIDTH-1:0]   shift_q;
  logic                    perr_q;
  logic                    serr_q;
  logic [DATA_WIDTH-1:0]   pdata_q;
  logic                    dv_q;
  logic                    pe_q;
  logic                    se_q;

  logic [PRESC_W-1:0] half_w;
  logic [PRESC_W-1:0] edge_d;
  logic               mid_lo;
  logic               mid_c;
  logic               mid_hi;
  logic               chk;
  logic               wrap;
  logic               maj;
  logic               go_start;

  always_comb begin
    half_w   = presc_q >> 1;
    wrap     = (edge_q == presc_q - ONE);
    edge_d   = wrap ? '0 : edge_q + ONE;
    mid_lo   = (edge_q == half_w - ONE);
    mid_c    = (edge_q == half_w);
    mid_hi   = (edge_q == half_w + ONE);
    chk      = (edge_q == half_w + TWO);
    maj      = (smp_q[0] & smp_q[1]) |
               (smp_q[0] & smp_q[2]) |
               (smp_q[1] & smp_q[2]);
    // A low line at the end of STOP is the next start bit.
    go_start = !rx_s_q &&
               (state_q == IDLE || (state_q == STOP && wrap));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      edge_q    <= '0;
      bit_q     <= '0;
      presc_q   <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      smp_q     <= 3'b111;
      shift_q   <= '0;
      perr_q    <= 1'b0;
      serr_q    <= 1'b0;
      pdata_q   <= '0;
      dv_q      <= 1'b0;
      pe_q      <= 1'b0;
      se_q      <= 1'b0;
    end else begin
      rx_meta_q <= RX_IN;
      rx_s_q    <= rx_meta_q;
      dv_q      <= 1'b0;
      pe_q      <= 1'b0;
      se_q      <= 1'b0;

      if (state_q != IDLE) begin
        if (mid_lo) smp_q[0] <= rx_s_q;
        if (mid_c)  smp_q[1] <= rx_s_q;
        if (mid_hi) smp_q[2] <= rx_s_q;
      end

      unique case (state_q)
        IDLE: ;
        START: begin
          edge_q <= edge_d;
          if (chk && maj) begin
            state_q <= IDLE;
          end else if (wrap) begin
            state_q <= DATA;
            bit_q   <= '0;
          end
        end
        DATA: begin
          edge_q <= edge_d;
          if (chk) shift_q[bit_q] <= maj;
          if (wrap) begin
            if (bit_q == LAST_BIT)
              state_q <= par_en_q ? PARITY : STOP;
            else
              bit_q <= bit_q + BONE;
          end
        end
        PARITY: begin
          edge_q <= edge_d;
          if (chk) perr_q <= maj ^ par_typ_q ^ (^shift_q);
          if (wrap) state_q <= STOP;
        end
        STOP: begin
          edge_q <= edge_d;
          if (chk) serr_q <= ~maj;
          if (wrap) begin
            if (!perr_q && !serr_q) begin
              dv_q    <= 1'b1;
              pdata_q <= shift_q;
            end else begin
              pe_q <= perr_q;
              se_q <= serr_q;
            end
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase

      if (go_start) begin
        state_q   <= START;
        edge_q    <= '0;
        presc_q   <= Prescale;
        par_en_q  <= PAR_EN;
        par_typ_q <= PAR_TYP;
        perr_q    <= 1'b0;
        serr_q    <= 1'b0;
      end
    end
  end

  assign P_DATA     = pdata_q;
  assign Data_Valid = dv_q;
  assign par_err    = pe_q;
  assign stp_err    = se_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core: frames are driven serially and the
// expected strobe, data and arrival cycle are queued for the monitor.
module tb_uart_rx_core;

  logic       clk = 1'b0;
  logic       rst;
  logic       RX_IN;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic [5:0] Prescale;
  logic [7:0] P_DATA;
  logic       Data_Valid;
  logic       par_err;
  logic       stp_err;

  uart_rx_core dut (
    .clk        (clk),
    .rst        (rst),
    .RX_IN      (RX_IN),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .Prescale   (Prescale),
    .P_DATA     (P_DATA),
    .Data_Valid (Data_Valid),
    .par_err    (par_err),
    .stp_err    (stp_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] flags;
    logic [7:0] data;
    int         cyc;
  } exp_t;

  exp_t       sbq[$];
  int         dv_cyc[$];
  exp_t       e;
  int         cyc = 0;
  int         total = 0;
  int         bad = 0;
  logic [7:0] last_good = 8'h00;

  always @(posedge clk) cyc++;

  // flags = {Data_Valid, par_err, stp_err}
  always @(negedge clk) begin
    if (Data_Valid || par_err || stp_err) begin
      if (Data_Valid) dv_cyc.push_back(cyc);
      total++;
      assert (sbq.size() > 0) else begin
        bad++;
        $error("FAIL strobe_unexpected obs=%b exp=none",
               {Data_Valid, par_err, stp_err});
      end
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        total++;
        assert ({Data_Valid, par_err, stp_err} === e.flags) else begin
          bad++;
          $error("FAIL flags obs=%b exp=%b",
                 {Data_Valid, par_err, stp_err}, e.flags);
        end
        total++;
        assert (P_DATA === e.data) else begin
          bad++;
          $error("FAIL p_data obs=%h exp=%h", P_DATA, e.data);
        end
        total++;
        assert (cyc === e.cyc) else begin
          bad++;
          $error("FAIL latency obs=%0d exp=%0d", cyc, e.cyc);
        end
      end
    end
  end

  task automatic send_frame(input logic [7:0] d, input int p,
                            input logic pe, input logic pt,
                            input logic pbit, input logic stop,
                            input int abort_bit);
    logic bits [11];
    int   n;
    exp_t x;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[i+1] = d[i];
    n = pe ? 11 : 10;
    if (pe) bits[9] = pbit;
    bits[n-1] = stop;
    Prescale = 6'(p);
    PAR_EN   = pe;
    PAR_TYP  = pt;
    for (int i = 0; i < n; i++) begin
      RX_IN = bits[i];
      if (i == 0 && abort_bit < 0) begin
        x.cyc = cyc + 3 + n * p;
        if (pe && (pbit !== ((^d) ^ pt)))
          x.flags = stop ? 3'b010 : 3'b011;
        else
          x.flags = stop ? 3'b100 : 3'b001;
        x.data = x.flags[2] ? d : last_good;
        if (x.flags[2]) last_good = d;
        sbq.push_back(x);
      end
      if (i == 1) begin
        // mid-frame config changes must be ignored
        Prescale = (p == 32) ? 6'd8 : 6'd32;
        PAR_EN   = ~pe;
        PAR_TYP  = ~pt;
      end
      if (i == abort_bit) begin
        repeat (p / 2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        RX_IN = 1'b1;
        total++;
        assert ({Data_Valid, par_err, stp_err} === 3'b000) else begin
          bad++;
          $error("FAIL rst_mid_strobes obs=%b exp=000",
                 {Data_Valid, par_err, stp_err});
        end
        total++;
        assert (P_DATA === 8'h00) else begin
          bad++;
          $error("FAIL rst_mid_pdata obs=%h exp=00", P_DATA);
        end
        last_good = 8'h00;
        rst = 1'b0;
        return;
      end
      repeat (p) @(negedge clk);
    end
    RX_IN = 1'b1;
  endtask

  task automatic idle_drain(input int n, input string tag);
    RX_IN = 1'b1;
    repeat (n) @(negedge clk);
    total++;
    assert (sbq.size() == 0) else begin
      bad++;
      $error("FAIL %s_drain obs=%0d pending exp=0", tag, sbq.size());
    end
  endtask

  initial begin
    rst      = 1'b1;
    RX_IN    = 1'b1;
    PAR_EN   = 1'b0;
    PAR_TYP  = 1'b0;
    Prescale = 6'd8;
    repeat (3) @(negedge clk);
    total++;
    assert (P_DATA === 8'h00) else begin
      bad++;
      $error("FAIL rst_pdata obs=%h exp=00", P_DATA);
    end
    total++;
    assert ({Data_Valid, par_err, stp_err} === 3'b000) else begin
      bad++;
      $error("FAIL rst_strobes obs=%b exp=000",
             {Data_Valid, par_err, stp_err});
    end
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // 1: good frame with even parity
    send_frame(8'hA5, 8, 1'b1, 1'b0, 1'b0, 1'b1, -1);
    idle_drain(20, "t1");

    // 2: odd parity, wrong parity bit
    send_frame(8'h01, 16, 1'b1, 1'b1, 1'b1, 1'b1, -1);
    idle_drain(30, "t2");
    total++;
    assert (P_DATA === 8'hA5) else begin
      bad++;
      $error("FAIL t2_hold obs=%h exp=a5", P_DATA);
    end

    // 3: stop bit low
    send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    idle_drain(20, "t3");

    // 4: short glitch, then good frame
    Prescale = 6'd16;
    RX_IN    = 1'b0;
    repeat (4) @(negedge clk);
    idle_drain(60, "t4a");
    send_frame(8'hFF, 16, 1'b0, 1'b0, 1'b0, 1'b1, -1);
    idle_drain(30, "t4b");

    // 5: back-to-back frames at prescale 32
    dv_cyc.delete();
    send_frame(8'h3C, 32, 1'b0, 1'b0, 1'b0, 1'b1, -1);
    send_frame(8'hC3, 32, 1'b0, 1'b0, 1'b0, 1'b1, -1);
    idle_drain(60, "t5");
    total++;
    assert (dv_cyc.size() == 2) else begin
      bad++;
      $error("FAIL t5_count obs=%0d exp=2", dv_cyc.size());
    end
    if (dv_cyc.size() == 2) begin
      total++;
      assert (dv_cyc[1] - dv_cyc[0] == 320) else begin
        bad++;
        $error("FAIL t5_gap obs=%0d exp=320", dv_cyc[1] - dv_cyc[0]);
      end
    end

    // 6: reset during data bit 4, then a clean frame
    send_frame(8'h77, 8, 1'b0, 1'b0, 1'b0, 1'b1, 5);
    idle_drain(40, "t6a");
    send_frame(8'h12, 8, 1'b0, 1'b0, 1'b0, 1'b1, -1);
    idle_drain(20, "t6b");
    total++;
    assert (P_DATA === 8'h12) else begin
      bad++;
      $error("FAIL t6_pdata obs=%h exp=12", P_DATA);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
